serial_paralelo_rx: RTL and testbench

Receive-side lane front end of the PCIe-style physical layer: takes one serial lane bit per clock, finds byte alignment on the COM symbol, declares the lane active after a run of consecutive COM symbols, and reassembles the following data bytes into 32-bit words with a one-cycle valid strobe. It is the inverse of the transmit lane path (32→8 demux plus parallel-to-serial). Two instances feed the RX un-striping stage, one per lane.

---
 rtl/phy_rx_pkg.sv | 21 ++
 rtl/com_aligner.sv | 88 ++++++++
 rtl/serial_paralelo_rx.sv | 99 +++++++++
 tb/tb_serial_paralelo_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/phy_rx_pkg.sv
// Shared constants, widths and FSM encoding for the PHY receive lane front end.
package phy_rx_pkg;

  localparam logic [7:0]  COM_SYMBOL_DEF = 8'hBC;
  localparam int unsigned BC_REQ_DEF     = 4;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BIT_CNT_W   = 3;
  localparam int unsigned BC_CNT_W    = 4;
  localparam int unsigned BYTE_IDX_W  = 2;
  localparam int unsigned ERR_W       = 8;
  localparam int unsigned PART_W      = WORD_W - BYTE_W;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/com_aligner.sv
// Bit-sliding COM search, byte framing and lane activation for one serial lane.
module com_aligner
  import phy_rx_pkg::*;
#(
  parameter logic [7:0]  COM_SYMBOL = COM_SYMBOL_DEF,
  parameter int unsigned BC_REQ     = BC_REQ_DEF
) (
  input  logic              clk_32f,
  input  logic              reset_L,
  input  logic              data_in,
  output logic              byte_stb_c,
  output logic [BYTE_W-1:0] byte_c,
  output logic              active
);

  rx_state_e             state_q, state_d;
  logic [BYTE_W-2:0]     sr_q, sr_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BC_CNT_W-1:0]   bc_cnt_q, bc_cnt_d;
  logic                  active_q, active_d;
  logic [BYTE_W-1:0]     cb;
  logic                  boundary;

  assign active = active_q;

  // Next state: candidate byte is the seven held bits plus the bit arriving now.
  always_comb begin
    cb         = {sr_q, data_in};
    sr_d       = cb[BYTE_W-2:0];
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bc_cnt_d   = bc_cnt_q;
    active_d   = active_q;
    byte_stb_c = 1'b0;
    byte_c     = cb;
    boundary   = (bit_cnt_q == BIT_CNT_W'(7));

    case (state_q)
      SEARCH: begin
        bit_cnt_d = '0;
        if (cb == COM_SYMBOL) begin
          state_d  = LOCK;
          bc_cnt_d = BC_CNT_W'(1);
        end
      end
      LOCK: begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        if (boundary) begin
          if (cb == COM_SYMBOL) begin
            bc_cnt_d = bc_cnt_q + BC_CNT_W'(1);
            if ((5'(bc_cnt_q) + 5'd1) == 5'(BC_REQ)) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d   = SEARCH;
            bc_cnt_d  = '0;
            bit_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
        byte_stb_c = boundary;
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      active_q  <= active_d;
    end
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial lane receiver: COM alignment plus 4-byte word assembly with a valid strobe.
// Optional SERIAL_RX_ERR_CNT_EN enables the saturating dropped-partial-word counter.
module serial_paralelo_rx
  import phy_rx_pkg::*;
#(
  parameter logic [7:0]  COM_SYMBOL = COM_SYMBOL_DEF,
  parameter int unsigned BC_REQ     = BC_REQ_DEF
) (
  input  logic              clk_32f,
  input  logic              reset_L,
  input  logic              data_in,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  output logic              active,
  output logic [ERR_W-1:0]  err_count
);

  logic                   byte_stb_c;
  logic [BYTE_W-1:0]      byte_c;
  logic [BYTE_IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [PART_W-1:0]      part_q, part_d;
  logic [WORD_W-1:0]      data_out_q, data_out_d;
  logic                   valid_q, valid_d;

  com_aligner #(
    .COM_SYMBOL (COM_SYMBOL),
    .BC_REQ     (BC_REQ)
  ) u_aligner (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .byte_stb_c (byte_stb_c),
    .byte_c     (byte_c),
    .active     (active)
  );

  assign data_out  = data_out_q;
  assign valid_out = valid_q;

  // Word assembly: COM mid-word drops the partial, fourth data byte publishes the word.
  always_comb begin
    byte_idx_d = byte_idx_q;
    part_d     = part_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    if (byte_stb_c) begin
      if (byte_c == COM_SYMBOL) begin
        byte_idx_d = '0;
      end else if (byte_idx_q == BYTE_IDX_W'(3)) begin
        data_out_d = {part_q, byte_c};
        valid_d    = 1'b1;
        byte_idx_d = '0;
      end else begin
        part_d     = {part_q[PART_W-BYTE_W-1:0], byte_c};
        byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      byte_idx_q <= '0;
      part_q     <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      part_q     <= part_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

`ifdef SERIAL_RX_ERR_CNT_EN
  logic [ERR_W-1:0] err_q, err_d;

  // Saturating count of partial words discarded by an idle COM.
  always_comb begin
    err_d = err_q;
    if (byte_stb_c && (byte_c == COM_SYMBOL) && (byte_idx_q != '0) &&
        (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed self-checking bench for serial_paralelo_rx (default COM 8'hBC, BC_REQ 4).
module tb_serial_paralelo_rx;

  logic        clk_32f = 1'b0;
  logic        reset_L;
  logic        data_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;
  logic [7:0]  err_count;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          strobes = 0;
  int          s0;
  int          n0;
  int          strobe_cyc[$];
  logic [31:0] last_word = 32'h0;
  logic [31:0] exp_err;

  serial_paralelo_rx dut (
    .clk_32f   (clk_32f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .err_count (err_count)
  );

  always #5 clk_32f = ~clk_32f;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, let the rising edge sample, observe at the next falling edge.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    @(negedge clk_32f);
    cyc++;
    if (valid_out === 1'b1) begin
      strobes++;
      strobe_cyc.push_back(cyc);
      last_word = data_out;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic send_com(input int n);
    for (int i = 0; i < n; i++) send_byte(8'hBC);
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  initial begin
`ifdef SERIAL_RX_ERR_CNT_EN
    exp_err = 32'd1;
`else
    exp_err = 32'd0;
`endif
    reset_L = 1'b0;
    data_in = 1'b0;
    #1;
    check("rst_data", data_out, 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_err", 32'(err_count), 32'h0);
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset_L = 1'b1;

    // Basic alignment and first word
    send_com(3);
    check("t1_active_after3", 32'(active), 32'h0);
    send_com(1);
    check("t1_active_after4", 32'(active), 32'h1);
    s0 = strobes;
    send_word(32'hDEADBEEF);
    check("t1_valid", 32'(valid_out), 32'h1);
    check("t1_data", data_out, 32'hDEADBEEF);
    send_byte(8'hBC);
    check("t1_valid_low", 32'(valid_out), 32'h0);
    check("t1_data_hold", data_out, 32'hDEADBEEF);
    check("t1_strobe_cnt", 32'(strobes - s0), 32'd1);

    // Partial word dropped by an idle COM
    s0 = strobes;
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hBC);
    check("t4_no_strobe", 32'(strobes - s0), 32'd0);
    send_word(32'h01020304);
    check("t4_data", data_out, 32'h01020304);
    check("t4_strobe_cnt", 32'(strobes - s0), 32'd1);
    check("t4_err", 32'(err_count), exp_err);

    // Back-to-back words
    s0 = strobes;
    n0 = strobe_cyc.size();
    send_word(32'hA1A2A3A4);
    send_word(32'hB1B2B3B4);
    send_word(32'hC1C2C3C4);
    check("t6_strobe_cnt", 32'(strobes - s0), 32'd3);
    if (strobe_cyc.size() >= n0 + 3) begin
      check("t6_gap1", 32'(strobe_cyc[n0+1] - strobe_cyc[n0]), 32'd32);
      check("t6_gap2", 32'(strobe_cyc[n0+2] - strobe_cyc[n0+1]), 32'd32);
    end else begin
      check("t6_strobes_seen", 32'(strobe_cyc.size() - n0), 32'd3);
    end
    check("t6_last_word", last_word, 32'hC1C2C3C4);
    check("t6_err", 32'(err_count), exp_err);

    // Reset in the middle of a word
    send_byte(8'h11);
    send_byte(8'h22);
    reset_L = 1'b0;
    #1;
    check("t5_rst_data", data_out, 32'h0);
    check("t5_rst_valid", 32'(valid_out), 32'h0);
    check("t5_rst_active", 32'(active), 32'h0);
    check("t5_rst_err", 32'(err_count), 32'h0);
    @(negedge clk_32f);
    reset_L = 1'b1;
    s0 = strobes;
    send_com(3);
    send_word(32'h11223344);
    check("t5_active_short", 32'(active), 32'h0);
    check("t5_no_strobe", 32'(strobes - s0), 32'd0);
    send_com(3);
    check("t5_active_after3", 32'(active), 32'h0);
    send_com(1);
    check("t5_active_after4", 32'(active), 32'h1);
    send_word(32'h11223344);
    check("t5_data", data_out, 32'h11223344);
    check("t5_strobe_cnt", 32'(strobes - s0), 32'd1);

    // Alignment found from an arbitrary bit offset
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_com(3);
    check("t2_active_after3", 32'(active), 32'h0);
    send_com(1);
    check("t2_active_after4", 32'(active), 32'h1);
    s0 = strobes;
    send_word(32'h12345678);
    check("t2_data", data_out, 32'h12345678);
    check("t2_strobe_cnt", 32'(strobes - s0), 32'd1);

    // Broken COM run falls back to search
    do_reset();
    send_com(3);
    send_byte(8'h55);
    check("t3_active_after55", 32'(active), 32'h0);
    send_com(3);
    check("t3_active_run2_3", 32'(active), 32'h0);
    send_com(1);
    check("t3_active_run2_4", 32'(active), 32'h1);
    s0 = strobes;
    send_word(32'hCAFEF00D);
    check("t3_data", data_out, 32'hCAFEF00D);
    check("t3_strobe_cnt", 32'(strobes - s0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
